pipelined_carry_adder: RTL and testbench



---
 rtl/pipelined_carry_adder.sv | 116 +++++++++++
 tb/tb_pipelined_carry_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder/subtractor: one operand slice per stage, carry registered
// between stages, operand skew and result deskew registers so the full word emerges at once.
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);
    localparam int SL = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_carry_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1");
        end
    endgenerate

    logic w_stall;

    assign w_stall  = g_stage[STAGES-1].r_valid && !out_ready;
    assign in_ready = !w_stall;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO = gi * SL;
            localparam int HI = WIDTH - LO;

            logic             w_v_in;
            logic             w_c_in;
            logic [HI-1:0]    w_a_in;
            logic [HI-1:0]    w_b_in;
            logic [SL:0]      w_slice;
            logic [LO+SL-1:0] w_sum_next;

            logic             r_valid;
            logic             r_carry;
            logic [LO+SL-1:0] r_sum;

            // Subtraction is folded in up front: a + ~b + ~cin, so later stages only add.
            if (gi == 0) begin : g_in
                assign w_v_in     = in_valid;
                assign w_c_in     = cin ^ sub;
                assign w_a_in     = a;
                assign w_b_in     = sub ? ~b : b;
                assign w_sum_next = w_slice[SL-1:0];
            end else begin : g_in
                assign w_v_in     = g_stage[gi-1].r_valid;
                assign w_c_in     = g_stage[gi-1].r_carry;
                assign w_a_in     = g_stage[gi-1].g_ops.r_a;
                assign w_b_in     = g_stage[gi-1].g_ops.r_b;
                assign w_sum_next = {w_slice[SL-1:0], g_stage[gi-1].r_sum};
            end

            assign w_slice = {1'b0, w_a_in[SL-1:0]} + {1'b0, w_b_in[SL-1:0]}
                           + {{SL{1'b0}}, w_c_in};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_sum   <= '0;
                end else if (!w_stall) begin
                    r_valid <= w_v_in;
                    if (w_v_in) begin
                        r_carry <= w_slice[SL];
                        r_sum   <= w_sum_next;
                    end
                end
            end

            if (gi < STAGES - 1) begin : g_ops
                logic [HI-SL-1:0] r_a;
                logic [HI-SL-1:0] r_b;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (!w_stall && w_v_in) begin
                        r_a <= w_a_in[HI-1:SL];
                        r_b <= w_b_in[HI-1:SL];
                    end
                end
            end else begin : g_last
                logic r_ovf;

                // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_ovf <= 1'b0;
                    end else if (!w_stall && w_v_in) begin
                        r_ovf <= w_a_in[SL-1] ^ w_b_in[SL-1] ^ w_slice[SL-1] ^ w_slice[SL];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign s         = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_carry;
    assign overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench: a 16-bit/4-stage and an 8-bit/1-stage instance share the stimulus,
// each with its own arithmetic reference scoreboard.
module tb_pipelined_carry_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, cin, sub;
    logic [15:0] a, b;

    logic        in_ready16, out_valid16, cout16, ovf16;
    logic [15:0] s16;
    logic        in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]  s8;

    pipelined_carry_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .s(s16), .cout(cout16), .overflow(ovf16)
    );

    pipelined_carry_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(out_ready),
        .s(s8), .cout(cout8), .overflow(ovf8)
    );

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t        q16[$];
    exp_t        q8[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_stall16 = -1000;
    int          last_stall8  = -1000;
    int          n_out16 = 0;
    int          n_out8  = 0;
    logic        prev_stall16 = 1'b0;
    logic        prev_stall8  = 1'b0;
    logic [18:0] held16 = '0;
    logic [10:0] held8  = '0;
    logic [17:0] last16 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic on the operands' unsigned and signed values.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic c, input logic sb_op, input int acc);
        exp_t   e;
        longint one = 1;
        longint m   = (one << w) - 1;
        longint ua  = longint'(av) & m;
        longint ub  = longint'(bv) & m;
        longint sa  = (ua > m / 2) ? ua - (m + 1) : ua;
        longint sbv = (ub > m / 2) ? ub - (m + 1) : ub;
        longint u;
        longint r;
        if (!sb_op) begin
            u      = ua + ub + longint'(c);
            r      = sa + sbv + longint'(c);
            e.cout = (u > m);
        end else begin
            u      = ua - ub - longint'(c);
            r      = sa - sbv - longint'(c);
            e.cout = (u >= 0);
        end
        e.s   = 16'(u & m);
        e.ovf = (r > m / 2) || (r < -(m / 2) - 1);
        e.acc = acc;
        return e;
    endfunction

    task automatic observe16();
        logic stall;
        exp_t e;
        stall = out_valid16 && !out_ready;
        check("in_ready16", 32'(in_ready16), 32'(!stall));
        if (prev_stall16) check("hold16", 32'({out_valid16, ovf16, cout16, s16}), 32'(held16));
        if (out_valid16 && out_ready) begin
            if (q16.size() == 0) begin
                check("stale16", 32'(out_valid16), 32'd0);
            end else begin
                e = q16.pop_front();
                check("s16", 32'(s16), 32'(e.s));
                check("cout16", 32'(cout16), 32'(e.cout));
                check("ovf16", 32'(ovf16), 32'(e.ovf));
                if (last_stall16 < e.acc) check("lat16", 32'(cyc - e.acc), 32'd4);
                last16 = {ovf16, cout16, s16};
                n_out16++;
            end
        end
        if (stall) last_stall16 = cyc;
        prev_stall16 = stall;
        held16 = {out_valid16, ovf16, cout16, s16};
        if (in_valid && in_ready16) q16.push_back(model(16, a, b, cin, sub, cyc));
    endtask

    task automatic observe8();
        logic stall;
        exp_t e;
        stall = out_valid8 && !out_ready;
        check("in_ready8", 32'(in_ready8), 32'(!stall));
        if (prev_stall8) check("hold8", 32'({out_valid8, ovf8, cout8, s8}), 32'(held8));
        if (out_valid8 && out_ready) begin
            if (q8.size() == 0) begin
                check("stale8", 32'(out_valid8), 32'd0);
            end else begin
                e = q8.pop_front();
                check("s8", 32'(s8), 32'(e.s));
                check("cout8", 32'(cout8), 32'(e.cout));
                check("ovf8", 32'(ovf8), 32'(e.ovf));
                if (last_stall8 < e.acc) check("lat8", 32'(cyc - e.acc), 32'd1);
                n_out8++;
            end
        end
        if (stall) last_stall8 = cyc;
        prev_stall8 = stall;
        held8 = {out_valid8, ovf8, cout8, s8};
        if (in_valid && in_ready8) q8.push_back(model(8, a, b, cin, sub, cyc));
    endtask

    task automatic tick();
        #1;
        observe16();
        observe8();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic c,
                      input logic sb_op);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = c;
        sub = sb_op;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            tick();
        end
    endtask

    initial begin
        int n_before;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ovalid16", 32'(out_valid16), 32'd0);
        check("rst_s16", 32'(s16), 32'd0);
        check("rst_flags16", 32'({cout16, ovf16}), 32'd0);
        check("rst_ready16", 32'(in_ready16), 32'd1);
        check("rst_ovalid8", 32'(out_valid8), 32'd0);
        rst = 1'b0;

        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        idle(5);
        check("dir_7fff_plus_1", 32'(last16), 32'({1'b1, 1'b0, 16'h8000}));
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle(5);
        check("dir_ffff_plus_1", 32'(last16), 32'({1'b0, 1'b1, 16'h0000}));
        op(16'h0005, 16'h0007, 1'b0, 1'b1);
        idle(5);
        check("dir_5_minus_7", 32'(last16), 32'({1'b0, 1'b0, 16'hFFFE}));
        op(16'h8000, 16'h0001, 1'b0, 1'b1);
        idle(5);
        check("dir_8000_minus_1", 32'(last16), 32'({1'b1, 1'b1, 16'h7FFF}));
        op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        idle(5);
        check("dir_slice_carry", 32'(last16), 32'({1'b0, 1'b0, 16'h0100}));

        n_before = n_out16;
        for (int i = 0; i < 8; i++) op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        idle(5);
        check("b2b_count16", 32'(n_out16 - n_before), 32'd8);

        for (int i = 0; i < 12; i++) begin
            out_ready = !(i >= 5 && i < 8);
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        out_ready = 1'b1;
        idle(6);

        for (int i = 0; i < 60; i++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            tick();
        end
        out_ready = 1'b1;
        idle(6);
        check("drain_q16", 32'(q16.size()), 32'd0);
        check("drain_q8", 32'(q8.size()), 32'd0);

        for (int i = 0; i < 3; i++) op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_ovalid16", 32'(out_valid16), 32'd0);
        check("midrst_s16", 32'(s16), 32'd0);
        check("midrst_flags16", 32'({cout16, ovf16}), 32'd0);
        check("midrst_ready16", 32'(in_ready16), 32'd1);
        check("midrst_ovalid8", 32'(out_valid8), 32'd0);
        q16.delete();
        q8.delete();
        prev_stall16 = 1'b0;
        prev_stall8  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        n_before = n_out16;
        op(16'h1234, 16'h0101, 1'b0, 1'b0);
        idle(6);
        check("post_rst_count16", 32'(n_out16 - n_before), 32'd1);
        check("post_rst_value16", 32'(last16), 32'({1'b0, 1'b0, 16'h1335}));
        check("post_rst_q16", 32'(q16.size()), 32'd0);
        check("post_rst_q8", 32'(q8.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
